// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: repeating MSB-first serial pattern transmitter with inter-frame gaps and abort.
// Optional idle-noise LFSR is built only when SEQ_TX_NOISE_EN is defined.
module seq_pattern_tx #(
    parameter int PAT_W = 7,
    parameter int CNT_W = 8,
    parameter int GAP   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep,
    input  logic             abort,
    output logic             serOut,
    output logic             busy,
    output logic             frame_end,
    output logic             done
);
    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
    state_t            state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [7:0]        gap_q, gap_d;
    logic              ser_q, ser_d, done_q, done_d, idle_bit;
`ifdef SEQ_TX_NOISE_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk) begin
        if (!rst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
    assign idle_bit = lfsr_q[0];
`else
    assign idle_bit = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start && !abort) begin
                state_d = S_SHIFT;
                pat_d   = pat_in;
                cnt_d   = (rep == '0) ? CNT_W'(1) : rep;
                bit_d   = BW'(PAT_W - 1);
            end
            S_SHIFT: begin
                if (abort) state_d = S_IDLE;
                else if (bit_q != '0) bit_d = bit_q - BW'(1);
                else begin
                    // counter saturates at zero rather than wrapping
                    cnt_d = cnt_q - CNT_W'(cnt_q != '0);
                    bit_d = BW'(PAT_W - 1);
                    if (cnt_q > CNT_W'(1)) begin
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = 8'(GAP - 1);
                        end
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (abort) state_d = S_IDLE;
                else if (gap_q == '0) state_d = S_SHIFT;
                else gap_d = gap_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
        ser_d = (state_d == S_SHIFT) ? pat_d[bit_d] : idle_bit;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end
    assign serOut    = ser_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_end = (state_q == S_SHIFT) && (bit_q == '0) && !abort;
    assign done      = done_q;
endmodule
